// File: rtl/shift_bank_pkg.sv
// Shared types for the shift_bank register file: command opcodes, stream FSM states
// and the opcode width.
package shift_bank_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP      = 3'd0,
        OP_LOAD     = 3'd1,
        OP_SHR      = 3'd2,
        OP_SHL      = 3'd3,
        OP_CLEAR    = 3'd4,
        OP_STREAM_R = 3'd5,
        OP_STREAM_L = 3'd6,
        OP_ROT_R    = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

endpackage

// File: rtl/shift_bank_cell.sv
// One WIDTH-bit register of the bank with clear, parallel load, shift right/left and
// rotate right; shout_o is the bit that the active shift or rotate pushes out.
module shift_bank_cell
    import shift_bank_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic             shr_i,
    input  logic             shl_i,
    input  logic             rot_i,
    input  logic             serial_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             shout_o
);

    logic [WIDTH-1:0] data_q, data_d;

    // NOTE: the hold-value default comes first so no path through this block infers a latch.
    always_comb begin
        data_d = data_q;
        if (clear_i) begin
            data_d = '0;
        end else if (load_i) begin
            data_d = data_i;
        end else if (shr_i) begin
            data_d = {serial_i, data_q[WIDTH-1:1]};
        end else if (shl_i) begin
            data_d = {data_q[WIDTH-2:0], serial_i};
        end else if (rot_i) begin
            data_d = {data_q[0], data_q[WIDTH-1:1]};
        end
    end

    // NOTE: state is updated with non-blocking assignments; every cell is reset, so the
    // whole bank clears in a single edge, unlike a RAM macro.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o  = data_q;
    assign shout_o = shl_i ? data_q[WIDTH-1] : data_q[0];

endmodule

// File: rtl/shift_bank.sv
// Bank of DEPTH shift registers with a command port, a multi-cycle stream FSM and a
// tri-state read port. Define SHIFT_BANK_ROTATE_EN to turn opcode 7 into rotate-right.
module shift_bank
    import shift_bank_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [OP_W-1:0]     cmd_op,
    input  logic [AW-1:0]       reg_select,
    input  logic [WIDTH-1:0]    data_in,
    input  logic                serial_in,
    input  logic [AW-1:0]       rd_select,
    input  logic                output_enable,
    output logic [WIDTH-1:0]    data_out,
    output logic                serial_out,
    output logic                busy,
    output logic                done
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [AW-1:0]    tgt_q;
    logic             dir_left_q;
    logic             busy_q;
    logic             done_q;
    logic             serial_out_q;

    op_e              op;
    logic             accept;
    logic             shifting;
    logic [AW-1:0]    sh_idx;
    logic [DEPTH-1:0] load_v, clear_v, shr_v, shl_v, rot_v, shout_v;
    logic [WIDTH-1:0] bank [DEPTH];

    assign op        = op_e'(cmd_op);
    assign cmd_ready = (state_q == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // While streaming, the latched target and direction drive the bank; new commands are ignored.
    always_comb begin
        load_v  = '0;
        clear_v = '0;
        shr_v   = '0;
        shl_v   = '0;
        rot_v   = '0;
        sh_idx  = reg_select;
        if (state_q == ST_STREAM) begin
            sh_idx = tgt_q;
            if (dir_left_q) begin
                shl_v[tgt_q] = 1'b1;
            end else begin
                shr_v[tgt_q] = 1'b1;
            end
        end else if (accept) begin
            case (op)
                OP_LOAD:     load_v[reg_select]  = 1'b1;
                OP_CLEAR:    clear_v[reg_select] = 1'b1;
                OP_SHR,
                OP_STREAM_R: shr_v[reg_select]   = 1'b1;
                OP_SHL,
                OP_STREAM_L: shl_v[reg_select]   = 1'b1;
`ifdef SHIFT_BANK_ROTATE_EN
                OP_ROT_R:    rot_v[reg_select]   = 1'b1;
`endif
                default:     ;
            endcase
        end
    end

    assign shifting = |{shr_v, shl_v, rot_v};

    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        shift_bank_cell #(.WIDTH(WIDTH)) u_cell (
            .clk      (clk),
            .reset    (reset),
            .load_i   (load_v[g]),
            .clear_i  (clear_v[g]),
            .shr_i    (shr_v[g]),
            .shl_i    (shl_v[g]),
            .rot_i    (rot_v[g]),
            .serial_i (serial_in),
            .data_i   (data_in),
            .data_o   (bank[g]),
            .shout_o  (shout_v[g])
        );
    end

    // cnt_q counts shifts already applied; the accept edge performs the first one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            tgt_q        <= '0;
            dir_left_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            serial_out_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (shifting) begin
                serial_out_q <= shout_v[sh_idx];
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept && (op == OP_STREAM_R || op == OP_STREAM_L)) begin
                        state_q    <= ST_STREAM;
                        tgt_q      <= reg_select;
                        dir_left_q <= (op == OP_STREAM_L);
                        cnt_q      <= CW'(1);
                        busy_q     <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign data_out   = output_enable ? bank[rd_select] : {WIDTH{1'bz}};
    assign serial_out = serial_out_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
